combo_status_display: RTL and testbench

//   Parametrised multi-digit status display for the combo-lock front panel. Tracks lock status
//   (LOCKED/OPEN/NEW/ALARM) in a registered FSM and drives NUM_DIGITS active-low 7-seg digits

---
 rtl/combo_status_display_if.sv | 23 ++
 rtl/combo_status_display.sv | 174 +++++++++++++++++
 tb/tb_combo_status_display.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/combo_status_display_if.sv
// Signal bundle between the combo-lock core and its status display.
// The lock side drives the status levels; the display side returns segments and flags.
interface combo_status_display_if #(
  parameter int NUM_DIGITS = 6
);
  logic                      open_i;
  logic                      new_i;
  logic                      alarm_i;
  logic                      ack_i;
  logic [7*NUM_DIGITS-1:0]   hex_o;
  logic                      alarm_o;
  logic                      busy_o;

  modport master (
    output open_i, new_i, alarm_i, ack_i,
    input  hex_o, alarm_o, busy_o
  );

  modport slave (
    input  open_i, new_i, alarm_i, ack_i,
    output hex_o, alarm_o, busy_o
  );
endinterface

// File: rtl/combo_status_display.sv
// Lock status FSM driving a multi-digit active-low 7-seg word that scrolls in from the
// right on every status change, with a sticky, blinking alarm.
module combo_status_display #(
  parameter int NUM_DIGITS = 6,
  parameter int SCROLL_DIV = 12_500_000,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  combo_status_display_if.slave bus
);

  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PW = $clog2(NUM_DIGITS + 1);

  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PTR_END     = PW'(NUM_DIGITS);
  localparam logic [PW-1:0] WORD_LEN    = PW'(4);
  localparam logic [6:0]    BLANK       = 7'h7F;

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_NEW    = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic                    alarm_reg, alarm_next;
  logic [SW-1:0]           sdiv_reg, sdiv_next;
  logic [BW-1:0]           bdiv_reg, bdiv_next;
  logic [PW-1:0]           ptr_reg, ptr_next;
  logic                    phase_reg, phase_next;
  logic                    busy_reg, busy_next;
  logic [6:0]              buf_reg [NUM_DIGITS];
  logic [6:0]              buf_next [NUM_DIGITS];
  logic [6:0]              shift_buf [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] hex_reg, hex_next;
  logic                    changed;
  logic                    step;

  // Character idx (0 = leftmost) of the word shown for each status.
  function automatic logic [6:0] word_char(input state_t s, input logic [1:0] idx);
    logic [6:0] g;
    g = BLANK;
    case (s)
      ST_LOCKED: g = 7'h7E;
      ST_OPEN: begin
        case (idx)
          2'd0:    g = 7'h01;
          2'd1:    g = 7'h18;
          2'd2:    g = 7'h30;
          default: g = 7'h09;
        endcase
      end
      ST_NEW: begin
        case (idx)
          2'd0:    g = 7'h09;
          2'd1:    g = 7'h30;
          2'd2:    g = 7'h41;
          default: g = BLANK;
        endcase
      end
      default: begin
        case (idx)
          2'd0:    g = 7'h08;
          2'd1:    g = 7'h71;
          2'd2:    g = 7'h08;
          default: g = 7'h7A;
        endcase
      end
    endcase
    return g;
  endfunction

  // One scroll step: everything moves left, the next character enters on the right.
  assign shift_buf[0] = (ptr_reg < WORD_LEN) ? word_char(state_reg, ptr_reg[1:0]) : BLANK;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_shift
      assign shift_buf[gi] = buf_reg[gi-1];
    end
  endgenerate

  always_comb begin
    alarm_next = bus.alarm_i | (alarm_reg & ~bus.ack_i);

    if (alarm_next)
      state_next = ST_ALARM;
    else if (bus.new_i)
      state_next = ST_NEW;
    else if (bus.open_i)
      state_next = ST_OPEN;
    else
      state_next = ST_LOCKED;

    changed = (state_next != state_reg);
    step    = (ptr_reg < PTR_END) && (sdiv_reg == SCROLL_LAST);

    if (changed)
      sdiv_next = '0;
    else if (step)
      sdiv_next = '0;
    else if (ptr_reg < PTR_END)
      sdiv_next = sdiv_reg + 1'b1;
    else
      sdiv_next = sdiv_reg;

    if (changed)
      ptr_next = '0;
    else if (step)
      ptr_next = ptr_reg + 1'b1;
    else
      ptr_next = ptr_reg;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (changed)
        buf_next[i] = BLANK;
      else if (step)
        buf_next[i] = shift_buf[i];
      else
        buf_next[i] = buf_reg[i];
    end

    // Blink runs only while in ALARM; any other status keeps the display lit.
    if (changed || state_next != ST_ALARM) begin
      phase_next = 1'b1;
      bdiv_next  = '0;
    end else if (bdiv_reg == BLINK_LAST) begin
      phase_next = ~phase_reg;
      bdiv_next  = '0;
    end else begin
      phase_next = phase_reg;
      bdiv_next  = bdiv_reg + 1'b1;
    end

    for (int i = 0; i < NUM_DIGITS; i++)
      hex_next[7*i +: 7] = phase_next ? buf_next[i] : BLANK;

    busy_next = (ptr_next < PTR_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_LOCKED;
      alarm_reg <= 1'b0;
      sdiv_reg  <= '0;
      bdiv_reg  <= '0;
      ptr_reg   <= '0;
      phase_reg <= 1'b1;
      busy_reg  <= 1'b1;
      buf_reg   <= '{default: BLANK};
      hex_reg   <= '1;
    end else begin
      state_reg <= state_next;
      alarm_reg <= alarm_next;
      sdiv_reg  <= sdiv_next;
      bdiv_reg  <= bdiv_next;
      ptr_reg   <= ptr_next;
      phase_reg <= phase_next;
      busy_reg  <= busy_next;
      buf_reg   <= buf_next;
      hex_reg   <= hex_next;
    end
  end

  assign bus.hex_o   = hex_reg;
  assign bus.alarm_o = alarm_reg;
  assign bus.busy_o  = busy_reg;

endmodule

// File: tb/tb_combo_status_display.sv
// Self-checking bench: directed scenarios plus random input activity, compared every cycle
// against a model that derives the display from the status and the time since it changed.
module tb_combo_status_display;

  localparam int N    = 6;
  localparam int SDIV = 2;
  localparam int BDIV = 4;

  logic clk;
  logic rst_n;

  combo_status_display_if #(.NUM_DIGITS(N)) bus ();

  combo_status_display #(
    .NUM_DIGITS(N),
    .SCROLL_DIV(SDIV),
    .BLINK_DIV (BDIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: status (0 LOCKED, 1 OPEN, 2 NEW, 3 ALARM), alarm latch, cycles since last change.
  int m_state = 0;
  bit m_latch = 1'b0;
  int m_age   = 0;

  logic [6:0] words [4][4] = '{
    '{7'h7E, 7'h7E, 7'h7E, 7'h7E},
    '{7'h01, 7'h18, 7'h30, 7'h09},
    '{7'h09, 7'h30, 7'h41, 7'h7F},
    '{7'h08, 7'h71, 7'h08, 7'h7A}
  };

  function automatic int steps_done();
    int k;
    k = m_age / SDIV;
    if (k > N) k = N;
    return k;
  endfunction

  function automatic logic [7*N-1:0] exp_hex();
    logic [7*N-1:0] h;
    int k;
    h = '1;
    k = steps_done();
    if (m_state == 3 && ((m_age / BDIV) % 2) == 1)
      return h;
    for (int d = 0; d < N; d++)
      if (d < k && (k - 1 - d) < 4)
        h[7*d +: 7] = words[m_state][k-1-d];
    return h;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hex"},   64'(bus.hex_o),   64'(exp_hex()));
    check({tag, ".alarm"}, 64'(bus.alarm_o), 64'(m_latch));
    check({tag, ".busy"},  64'(bus.busy_o),  64'(steps_done() < N));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_latch = 1'b0;
    m_age   = 0;
  endtask

  // Advance one clock: model samples the same inputs the DUT sees, outputs checked on negedge.
  task automatic tick(input string tag);
    int ns;
    @(posedge clk);
    m_latch = bus.alarm_i | (m_latch & ~bus.ack_i);
    if (m_latch)         ns = 3;
    else if (bus.new_i)  ns = 2;
    else if (bus.open_i) ns = 1;
    else                 ns = 0;
    if (ns != m_state) begin
      m_state = ns;
      m_age   = 0;
    end else begin
      m_age++;
    end
    @(negedge clk);
    check_all(tag);
    $display("cyc %s st=%0d alarm=%0d busy=%0d hex=%h", tag, m_state, bus.alarm_o, bus.busy_o, bus.hex_o);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.open_i  = 1'b0;
    bus.new_i   = 1'b0;
    bus.alarm_i = 1'b0;
    bus.ack_i   = 1'b0;
    model_reset();

    // Reset state, then the "----" word scrolls in.
    repeat (3) @(negedge clk);
    check_all("reset");
    #2 rst_n = 1'b1;
    run("locked", 14);

    // OPEN
    bus.open_i = 1'b1;
    run("open", 14);

    // Single-cycle alarm pulse, then blink well past the scroll end.
    bus.alarm_i = 1'b1;
    tick("alarm_set");
    bus.alarm_i = 1'b0;
    run("alarm_blink", 24);

    // Ack coinciding with alarm keeps the latch; a clean ack releases it.
    bus.alarm_i = 1'b1;
    bus.ack_i   = 1'b1;
    tick("ack_with_alarm");
    bus.alarm_i = 1'b0;
    bus.ack_i   = 1'b0;
    run("alarm_hold", 5);
    bus.ack_i = 1'b1;
    tick("ack_clear");
    bus.ack_i = 1'b0;
    run("open_again", 14);

    // Abort a scroll mid-way: leave OPEN, return, then switch to NEW at step 3.
    bus.open_i = 1'b0;
    run("to_locked", 3);
    bus.open_i = 1'b1;
    run("open_partial", 6);
    bus.new_i = 1'b1;
    run("new_abort", 14);
    bus.new_i = 1'b0;
    run("back_open", 4);

    // Random activity.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0) bus.open_i = ~bus.open_i;
      if ($urandom_range(0, 9) == 0) bus.new_i  = ~bus.new_i;
      bus.alarm_i = ($urandom_range(0, 39) == 0);
      bus.ack_i   = ($urandom_range(0, 9) == 0);
      tick("rand");
    end

    // Asynchronous reset in the middle of an alarm blink.
    bus.open_i  = 1'b0;
    bus.new_i   = 1'b0;
    bus.ack_i   = 1'b0;
    bus.alarm_i = 1'b1;
    tick("alarm_again");
    bus.alarm_i = 1'b0;
    run("alarm_blink2", 6);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    m_age = 1;
    check_all("post_reset");
    run("locked_after_reset", 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
